mem_responder: RTL and testbench

Single-port byte-addressed memory that serves the pipelined core's unified instruction/data accesses through a valid/ready request channel and a one-cycle response pulse. Handles RV32 load/store widths from funct3: lane selection, byte/halfword store merge, and load sign/zero extension. A programmable wait-state counter models slow memory. The core sees variable latency instead of a fixed-cycle array.

---
 rtl/mem_resp_pkg.sv | 41 ++++
 rtl/mem_lane_fmt.sv | 78 +++++++
 rtl/mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_mem_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// ----------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the mem_responder block:
//   - RV32 load/store funct3 encodings
//   - responder FSM state type
//   - little-endian lane extraction helpers
// Optional feature macro used by the block: MEM_ALIGN_CHECK_EN
// ----------------------------------------------------------------------------
package mem_resp_pkg;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Byte at little-endian lane 0..3
    function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                             input logic [1:0]  lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

    // Halfword selected by addr[1] (0 = low half, 1 = high half)
    function automatic logic [15:0] lane_half(input logic [31:0] word,
                                              input logic        hsel);
        return hsel ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// ----------------------------------------------------------------------------
// mem_lane_fmt
// Combinational lane logic for RV32 loads and stores.
//   old_word_i  : current contents of the addressed word
//   wdata_i     : store data, right-aligned
//   funct3_i    : RV32 load/store funct3
//   we_i        : 1 = store, 0 = load
//   addr_lo_i   : byte offset addr[1:0]
//   store_word_o: old word with the store lanes merged in
//   load_data_o : sign/zero extended load result
//   reject_o    : reserved funct3 (and, with MEM_ALIGN_CHECK_EN, misalignment)
// Optional feature macro: MEM_ALIGN_CHECK_EN
// ----------------------------------------------------------------------------
module mem_lane_fmt
    import mem_resp_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    input  logic        we_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] store_word_o,
    output logic [31:0] load_data_o,
    output logic        reject_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        reserved_s;

    assign byte_s = lane_byte(old_word_i, addr_lo_i);
    assign half_s = lane_half(old_word_i, addr_lo_i[1]);

    // Stores only define 000..010; loads additionally define 100 and 101
    assign reserved_s = we_i ? (funct3_i[2] || (funct3_i == 3'b011))
                             : ((funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11));

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_s;
    // Halfword needs addr[0]=0, word needs addr[1:0]=0 (funct3[1:0] gives width)
    assign misalign_s = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
    assign reject_o = reserved_s || misalign_s;
`else
    assign reject_o = reserved_s;
`endif

    // Load formatting
    always_comb begin
        load_data_o = 32'h0000_0000;
        case (funct3_i)
            F3_LB:   load_data_o = {{24{byte_s[7]}}, byte_s};
            F3_LBU:  load_data_o = {24'h00_0000, byte_s};
            F3_LH:   load_data_o = {{16{half_s[15]}}, half_s};
            F3_LHU:  load_data_o = {16'h0000, half_s};
            F3_LW:   load_data_o = old_word_i;
            default: load_data_o = 32'h0000_0000;
        endcase
    end

    // Store lane merge; untouched lanes keep the old contents
    always_comb begin
        store_word_o = old_word_i;
        case (funct3_i)
            F3_SB: store_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            F3_SH: begin
                if (addr_lo_i[1]) begin
                    store_word_o[31:16] = wdata_i[15:0];
                end else begin
                    store_word_o[15:0] = wdata_i[15:0];
                end
            end
            F3_SW:   store_word_o = wdata_i;
            default: store_word_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
// Single-port byte-addressed memory with a valid/ready request channel and a
// one-cycle response pulse. A programmable wait-state counter inserts
// WAIT_CYCLES extra cycles between acceptance and response.
// Parameters:
//   ADDR_W      : byte-address width; array holds 2**(ADDR_W-2) words
//   WAIT_CYCLES : extra latency cycles, 0..15
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   req_valid  : request present         req_ready : request accepted this cycle
//   req_we     : 1 = store, 0 = load     req_funct3: RV32 load/store width
//   req_addr   : byte address            req_wdata : right-aligned store data
//   rsp_valid  : one-cycle completion    rsp_rdata : formatted load data (0 for stores)
//   rsp_err    : access rejected (only with MEM_ALIGN_CHECK_EN)
// Optional feature macro: MEM_ALIGN_CHECK_EN
// ----------------------------------------------------------------------------
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned DEPTH     = 2 ** (ADDR_W - 2);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit          HAS_WAIT  = (WAIT_CYCLES != 0);

    state_e              state_q, state_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic                ready_q;
    logic                rsp_valid_q;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                lat_we_q;
    logic [2:0]          lat_funct3_q;
    logic [ADDR_W-1:0]   lat_addr_q;
    logic [31:0]         lat_wdata_q;

    logic [31:0]         mem_q [DEPTH];

    logic                accept_s;
    logic                enter_resp_s;
    logic                cur_we_s;
    logic [2:0]          cur_funct3_s;
    logic [ADDR_W-1:0]   cur_addr_s;
    logic [31:0]         cur_wdata_s;
    logic [ADDR_W-3:0]   word_idx_s;
    logic [31:0]         old_word_s;
    logic [31:0]         store_word_s;
    logic [31:0]         load_data_s;
    logic                reject_s;
    logic                wr_en_s;

    assign accept_s = req_valid && ready_q;

    // The access performed on the edge entering RESP belongs to the latched
    // request when coming from WAIT, otherwise (zero wait states) to the
    // request being accepted on this very edge.
    assign cur_we_s     = (state_q == WAIT) ? lat_we_q     : req_we;
    assign cur_funct3_s = (state_q == WAIT) ? lat_funct3_q : req_funct3;
    assign cur_addr_s   = (state_q == WAIT) ? lat_addr_q   : req_addr;
    assign cur_wdata_s  = (state_q == WAIT) ? lat_wdata_q  : req_wdata;

    assign word_idx_s = cur_addr_s[ADDR_W-1:2];
    assign old_word_s = mem_q[word_idx_s];

    mem_lane_fmt u_fmt (
        .old_word_i   (old_word_s),
        .wdata_i      (cur_wdata_s),
        .funct3_i     (cur_funct3_s),
        .we_i         (cur_we_s),
        .addr_lo_i    (cur_addr_s[1:0]),
        .store_word_o (store_word_s),
        .load_data_o  (load_data_s),
        .reject_o     (reject_s)
    );

    assign enter_resp_s = (state_d == RESP);
    assign wr_en_s      = enter_resp_s && cur_we_s && !reject_s;

    // Next-state and wait counter
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept_s) begin
                    if (HAS_WAIT) begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end else begin
                        state_d    = RESP;
                        wait_cnt_d = 4'd0;
                    end
                end else begin
                    state_d    = IDLE;
                    wait_cnt_d = 4'd0;
                end
            end
            WAIT: begin
                // Leave on the edge where the counter reaches zero
                if (wait_cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    wait_cnt_d = 4'd0;
                end else begin
                    state_d    = WAIT;
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    // Response data, captured on the edge entering RESP and held otherwise
    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (enter_resp_s) begin
            rsp_rdata_d = (cur_we_s || reject_s) ? 32'h0000_0000 : load_data_s;
`ifdef MEM_ALIGN_CHECK_EN
            rsp_err_d   = reject_s;
`else
            rsp_err_d   = 1'b0;
`endif
        end else begin
            rsp_rdata_d = rsp_rdata_q;
            rsp_err_d   = rsp_err_q;
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 4'd0;
            ready_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0000_0000;
            rsp_err_q    <= 1'b0;
            lat_we_q     <= 1'b0;
            lat_funct3_q <= 3'b000;
            lat_addr_q   <= '0;
            lat_wdata_q  <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            ready_q     <= (state_d != WAIT);
            rsp_valid_q <= (state_d == RESP);
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (accept_s) begin
                lat_we_q     <= req_we;
                lat_funct3_q <= req_funct3;
                lat_addr_q   <= req_addr;
                lat_wdata_q  <= req_wdata;
            end
        end
    end

    // Array write; contents survive reset, and a reset edge blocks the write
    always_ff @(posedge clk) begin
        if (rst && wr_en_s) begin
            mem_q[word_idx_s] <= store_word_s;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder. Three instances share clock, reset and
// request fields; each has its own req_valid:
//   u_w0 : WAIT_CYCLES = 0  (back-to-back throughput, read-after-write)
//   u_w1 : WAIT_CYCLES = 1  (latency, lane formatting, reserved/misaligned)
//   u_w3 : WAIT_CYCLES = 3  (reset during a pending store)
// ----------------------------------------------------------------------------
module tb_mem_responder;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;

    logic        v0 = 1'b0, v1 = 1'b0, v3 = 1'b0;
    logic        rdy0, rdy1, rdy3;
    logic        vld0, vld1, vld3;
    logic [31:0] rd0, rd1, rd3;
    logic        er0, er1, er3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld0), .rsp_rdata(rd0), .rsp_err(er0));

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld1), .rsp_rdata(rd1), .rsp_err(er1));

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld3), .rsp_rdata(rd3), .rsp_err(er3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // sel: 0 -> u_w0, 1 -> u_w1, 2 -> u_w3
    function automatic logic sel_rdy(input int sel);
        return (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy3;
    endfunction
    function automatic logic sel_vld(input int sel);
        return (sel == 0) ? vld0 : (sel == 1) ? vld1 : vld3;
    endfunction
    function automatic logic [31:0] sel_rd(input int sel);
        return (sel == 0) ? rd0 : (sel == 1) ? rd1 : rd3;
    endfunction
    function automatic logic sel_er(input int sel);
        return (sel == 0) ? er0 : (sel == 1) ? er1 : er3;
    endfunction

    task automatic set_valid(input int sel, input logic v);
        v0 = (sel == 0) ? v : 1'b0;
        v1 = (sel == 1) ? v : 1'b0;
        v3 = (sel == 2) ? v : 1'b0;
    endtask

    // One complete access: issue, check latency, ready in WAIT, data, pulse width
    task automatic access(input int sel, input logic we, input logic [2:0] f3,
                          input logic [7:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input string tag);
        int  lat;
        int  exp_lat;
        bit  got;
        exp_lat = (sel == 0) ? 1 : (sel == 1) ? 2 : 4;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        set_valid(sel, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (sel_rdy(sel)) got = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_ready"}, 32'(got), 32'd1);
        @(posedge clk);
        #1 set_valid(sel, 1'b0);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (sel_vld(sel)) got = 1'b1;
            else if (lat == 1) check({tag, "_ready_wait"}, 32'(sel_rdy(sel)), 32'd0);
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, sel_rd(sel), exp_rd);
        check({tag, "_err"}, 32'(sel_er(sel)), 32'(exp_err));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(sel_vld(sel)), 32'd0);
    endtask

    logic [31:0] v20;
    logic [31:0] exp_q [4];
    int          cnt;

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(rdy1), 32'd0);
        check("rst_valid", 32'(vld1), 32'd0);
        check("rst_rdata", rd1, 32'h0);
        check("rst_err", 32'(er1), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(rdy1), 32'd1);

        // WAIT_CYCLES = 1: word store/load and lane formatting
        access(1, 1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0, "sw10");
        access(1, 1'b0, 3'b010, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, "lw10");
        access(1, 1'b0, 3'b000, 8'h13, 32'h0,        32'hFFFFFFDE, 1'b0, "lb13");
        access(1, 1'b0, 3'b100, 8'h13, 32'h0,        32'h000000DE, 1'b0, "lbu13");
        access(1, 1'b0, 3'b001, 8'h12, 32'h0,        32'hFFFFDEAD, 1'b0, "lh12");
        access(1, 1'b0, 3'b101, 8'h10, 32'h0,        32'h0000BEEF, 1'b0, "lhu10");
        access(1, 1'b1, 3'b000, 8'h11, 32'h00000055, 32'h0,        1'b0, "sb11");
        access(1, 1'b0, 3'b010, 8'h10, 32'h0,        32'hDEAD55EF, 1'b0, "lw10b");

        // Misaligned and reserved accesses
        access(1, 1'b1, 3'b010, 8'h20, 32'h11223344, 32'h0, 1'b0, "sw20");
        access(1, 1'b0, 3'b010, 8'h22, 32'h0,
               ALIGN_EN ? 32'h0 : 32'h11223344, ALIGN_EN, "lw22");
        access(1, 1'b1, 3'b001, 8'h21, 32'h0000BEEF, 32'h0, ALIGN_EN, "sh21");
        v20 = ALIGN_EN ? 32'h11223344 : 32'h1122BEEF;
        access(1, 1'b0, 3'b010, 8'h20, 32'h0, v20, 1'b0, "lw20a");
        access(1, 1'b0, 3'b011, 8'h20, 32'h0, 32'h0, ALIGN_EN, "ld_rsv");
        access(1, 1'b1, 3'b100, 8'h20, 32'hFFFFFFFF, 32'h0, ALIGN_EN, "st_rsv");
        access(1, 1'b0, 3'b010, 8'h20, 32'h0, v20, 1'b0, "lw20b");

        // WAIT_CYCLES = 3: reset while a store is pending
        access(2, 1'b1, 3'b010, 8'h20, 32'hA1B2C3D4, 32'h0, 1'b0, "w3_sw20");
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 8'h20; req_wdata = 32'h12345678;
        set_valid(2, 1'b1);
        check("w3_idle_ready", 32'(rdy3), 32'd1);
        @(posedge clk);
        #1 set_valid(2, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("w3_rst_valid", 32'(vld3), 32'd0);
        check("w3_rst_ready", 32'(rdy3), 32'd0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (vld3) cnt++;
        end
        check("w3_no_rsp", 32'(cnt), 32'd0);
        access(2, 1'b0, 3'b010, 8'h20, 32'h0, 32'hA1B2C3D4, 1'b0, "w3_lw20");

        // WAIT_CYCLES = 0: four back-to-back requests with valid held high
        exp_q[0] = 32'h0;
        exp_q[1] = 32'hCAFEF00D;
        exp_q[2] = 32'h0;
        exp_q[3] = 32'h00000077;
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 8'h40; req_wdata = 32'hCAFEF00D;
        set_valid(0, 1'b1);
        check("w0_ready0", 32'(rdy0), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("w0_valid%0d", i), 32'(vld0), 32'd1);
            check($sformatf("w0_ready%0d", i), 32'(rdy0), 32'd1);
            check($sformatf("w0_rdata%0d", i), rd0, exp_q[i]);
            case (i)
                0: begin req_we = 1'b0; req_funct3 = 3'b010; req_addr = 8'h40; end
                1: begin req_we = 1'b1; req_funct3 = 3'b000; req_addr = 8'h41;
                         req_wdata = 32'h00000077; end
                2: begin req_we = 1'b0; req_funct3 = 3'b100; req_addr = 8'h41; end
                default: set_valid(0, 1'b0);
            endcase
        end
        @(negedge clk);
        check("w0_idle", 32'(vld0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
